// File: rtl/fetcher_if.sv
// Program-memory read bus between the fetcher (master) and instruction memory (slave).
interface fetcher_if #(
  parameter int unsigned ADDR_BITS = 8,
  parameter int unsigned DATA_BITS = 16
);
  logic                 mem_read_valid;
  logic [ADDR_BITS-1:0] mem_read_address;
  logic                 mem_read_ready;
  logic [DATA_BITS-1:0] mem_read_data;

  modport master (
    output mem_read_valid,
    output mem_read_address,
    input  mem_read_ready,
    input  mem_read_data
  );

  modport slave (
    input  mem_read_valid,
    input  mem_read_address,
    output mem_read_ready,
    output mem_read_data
  );
endinterface

// File: rtl/fetcher.sv
// Instruction fetcher with a one-entry reuse buffer. A fetch of the PC held in
// the buffer completes in one cycle without touching memory; any other fetch
// issues a program-memory read and refills the buffer when it returns.
module fetcher #(
  parameter int unsigned PROGRAM_MEM_ADDR_BITS = 8,
  parameter int unsigned PROGRAM_MEM_DATA_BITS = 16
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [3:0]                       core_state,
  input  logic [PROGRAM_MEM_ADDR_BITS-1:0] current_pc,
  input  logic                             flush,
  fetcher_if.master                        mem,
  output logic [2:0]                       fetcher_state,
  output logic [PROGRAM_MEM_DATA_BITS-1:0] instruction,
  output logic [7:0]                       hit_count
);

  localparam logic [3:0] CoreFetch  = 4'b0001;
  localparam logic [3:0] CoreDecode = 4'b0010;

  typedef enum logic [2:0] {
    StIdle     = 3'b000,
    StFetching = 3'b001,
    StFetched  = 3'b010
  } state_e;

  state_e                           state_q;
  logic                             valid_q;
  logic [PROGRAM_MEM_ADDR_BITS-1:0] addr_q;
  logic [PROGRAM_MEM_DATA_BITS-1:0] instr_q;
  logic [PROGRAM_MEM_ADDR_BITS-1:0] buf_pc_q;
  logic [PROGRAM_MEM_DATA_BITS-1:0] buf_instr_q;
  logic                             buf_valid_q;
  logic [7:0]                       hit_q;

  // A flush on the same edge as a would-be hit forces the miss path.
  logic hit;
  assign hit = buf_valid_q && (buf_pc_q == current_pc) && !flush;

  // Fetch FSM, reuse buffer and hit counter; all outputs are registered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      valid_q     <= 1'b0;
      addr_q      <= '0;
      instr_q     <= '0;
      buf_pc_q    <= '0;
      buf_instr_q <= '0;
      buf_valid_q <= 1'b0;
      hit_q       <= 8'd0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (core_state == CoreFetch) begin
            if (hit) begin
              instr_q <= buf_instr_q;
              state_q <= StFetched;
              if (hit_q != 8'hFF) hit_q <= hit_q + 8'd1;
            end else begin
              valid_q <= 1'b1;
              addr_q  <= current_pc;
              state_q <= StFetching;
            end
          end
        end
        StFetching: begin
          if (mem.mem_read_ready) begin
            instr_q     <= mem.mem_read_data;
            valid_q     <= 1'b0;
            state_q     <= StFetched;
            buf_pc_q    <= addr_q;
            buf_instr_q <= mem.mem_read_data;
            buf_valid_q <= 1'b1;
          end
        end
        StFetched: begin
          if (core_state == CoreDecode) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
      // Flush overrides any refill on the same edge; the delivered instruction stands.
      if (flush) buf_valid_q <= 1'b0;
    end
  end

  assign mem.mem_read_valid   = valid_q;
  assign mem.mem_read_address = addr_q;
  assign fetcher_state        = state_q;
  assign instruction          = instr_q;
  assign hit_count            = hit_q;

endmodule

// File: tb/tb_fetcher.sv
// Directed self-checking bench for the fetcher.
module tb_fetcher;
  localparam logic [3:0] CoreFetch  = 4'b0001;
  localparam logic [3:0] CoreDecode = 4'b0010;
  localparam logic [3:0] CoreExec   = 4'b0100;

  logic        clk;
  logic        reset;
  logic [3:0]  core_state;
  logic [7:0]  current_pc;
  logic        flush;
  logic [2:0]  fetcher_state;
  logic [15:0] instruction;
  logic [7:0]  hit_count;

  int checks;
  int errors;

  fetcher_if #(.ADDR_BITS(8), .DATA_BITS(16)) bus ();

  fetcher #(
    .PROGRAM_MEM_ADDR_BITS(8),
    .PROGRAM_MEM_DATA_BITS(16)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .core_state   (core_state),
    .current_pc   (current_pc),
    .flush        (flush),
    .mem          (bus.master),
    .fetcher_state(fetcher_state),
    .instruction  (instruction),
    .hit_count    (hit_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present FETCH for exactly one sampled edge.
  task automatic fetch(input logic [7:0] pc);
    core_state = CoreFetch;
    current_pc = pc;
    step();
    core_state = CoreExec;
  endtask

  // Return data from memory, then let the core move to DECODE.
  task automatic respond(input logic [15:0] data);
    bus.mem_read_ready = 1'b1;
    bus.mem_read_data  = data;
    step();
    bus.mem_read_ready = 1'b0;
    core_state = CoreDecode;
    step();
    core_state = CoreExec;
  endtask

  task automatic test_reset();
    checks++;
    if (fetcher_state !== 3'b000 || bus.mem_read_valid !== 1'b0 ||
        bus.mem_read_address !== 8'h00 || instruction !== 16'h0000 || hit_count !== 8'h00) begin
      errors++;
      $display("FAIL reset_outputs got st=%b v=%b a=%h i=%h h=%h want all zero",
               fetcher_state, bus.mem_read_valid, bus.mem_read_address, instruction, hit_count);
    end
  endtask

  task automatic test_miss();
    fetch(8'h05);
    checks++;
    if (bus.mem_read_valid !== 1'b1 || bus.mem_read_address !== 8'h05 || fetcher_state !== 3'b001) begin
      errors++;
      $display("FAIL miss_request got v=%b a=%h st=%b want 1 05 001",
               bus.mem_read_valid, bus.mem_read_address, fetcher_state);
    end
    step();
    step();
    checks++;
    if (bus.mem_read_valid !== 1'b1 || bus.mem_read_address !== 8'h05) begin
      errors++;
      $display("FAIL miss_hold got v=%b a=%h want 1 05", bus.mem_read_valid, bus.mem_read_address);
    end
    bus.mem_read_ready = 1'b1;
    bus.mem_read_data  = 16'hA1B2;
    step();
    bus.mem_read_ready = 1'b0;
    checks++;
    if (instruction !== 16'hA1B2 || fetcher_state !== 3'b010 || bus.mem_read_valid !== 1'b0) begin
      errors++;
      $display("FAIL miss_deliver got i=%h st=%b v=%b want a1b2 010 0",
               instruction, fetcher_state, bus.mem_read_valid);
    end
    core_state = CoreDecode;
    step();
    core_state = CoreExec;
    checks++;
    if (fetcher_state !== 3'b000 || instruction !== 16'hA1B2) begin
      errors++;
      $display("FAIL decode_to_idle got st=%b i=%h want 000 a1b2", fetcher_state, instruction);
    end
  endtask

  task automatic test_hit();
    core_state = CoreFetch;
    current_pc = 8'h05;
    step();
    checks++;
    if (fetcher_state !== 3'b010 || bus.mem_read_valid !== 1'b0 ||
        instruction !== 16'hA1B2 || hit_count !== 8'd1) begin
      errors++;
      $display("FAIL hit_one_cycle got st=%b v=%b i=%h h=%0d want 010 0 a1b2 1",
               fetcher_state, bus.mem_read_valid, instruction, hit_count);
    end
    // FETCH still held in FETCHED must not start another fetch.
    step();
    checks++;
    if (fetcher_state !== 3'b010 || bus.mem_read_valid !== 1'b0 || hit_count !== 8'd1) begin
      errors++;
      $display("FAIL fetched_hold got st=%b v=%b h=%0d want 010 0 1",
               fetcher_state, bus.mem_read_valid, hit_count);
    end
    core_state = CoreDecode;
    step();
    core_state = CoreExec;
  endtask

  task automatic test_flush();
    flush = 1'b1;
    step();
    flush = 1'b0;
    fetch(8'h05);
    checks++;
    if (bus.mem_read_valid !== 1'b1 || fetcher_state !== 3'b001 || hit_count !== 8'd1) begin
      errors++;
      $display("FAIL flush_forces_miss got v=%b st=%b h=%0d want 1 001 1",
               bus.mem_read_valid, fetcher_state, hit_count);
    end
    respond(16'hA1B2);
  endtask

  task automatic test_flush_with_ready();
    fetch(8'h07);
    bus.mem_read_ready = 1'b1;
    bus.mem_read_data  = 16'h1234;
    flush = 1'b1;
    step();
    bus.mem_read_ready = 1'b0;
    flush = 1'b0;
    checks++;
    if (instruction !== 16'h1234 || fetcher_state !== 3'b010) begin
      errors++;
      $display("FAIL flush_ready_deliver got i=%h st=%b want 1234 010", instruction, fetcher_state);
    end
    core_state = CoreDecode;
    step();
    fetch(8'h07);
    checks++;
    if (bus.mem_read_valid !== 1'b1 || fetcher_state !== 3'b001) begin
      errors++;
      $display("FAIL flush_ready_then_miss got v=%b st=%b want 1 001",
               bus.mem_read_valid, fetcher_state);
    end
    respond(16'h1234);
  endtask

  task automatic test_flush_with_hit();
    core_state = CoreFetch;
    current_pc = 8'h07;
    flush = 1'b1;
    step();
    flush = 1'b0;
    core_state = CoreExec;
    checks++;
    if (bus.mem_read_valid !== 1'b1 || fetcher_state !== 3'b001 || hit_count !== 8'd1) begin
      errors++;
      $display("FAIL flush_hit_is_miss got v=%b st=%b h=%0d want 1 001 1",
               bus.mem_read_valid, fetcher_state, hit_count);
    end
    respond(16'h1234);
  endtask

  task automatic test_full_width_compare();
    // Buffer holds 8'h07; 8'h87 differs only in the top bit.
    fetch(8'h87);
    checks++;
    if (bus.mem_read_valid !== 1'b1 || bus.mem_read_address !== 8'h87) begin
      errors++;
      $display("FAIL full_width_miss got v=%b a=%h want 1 87",
               bus.mem_read_valid, bus.mem_read_address);
    end
    respond(16'h5555);
  endtask

  task automatic test_ready_ignored();
    bus.mem_read_ready = 1'b1;
    bus.mem_read_data  = 16'hFFFF;
    step();
    step();
    bus.mem_read_ready = 1'b0;
    checks++;
    if (instruction !== 16'h5555 || fetcher_state !== 3'b000 || bus.mem_read_valid !== 1'b0) begin
      errors++;
      $display("FAIL ready_in_idle got i=%h st=%b v=%b want 5555 000 0",
               instruction, fetcher_state, bus.mem_read_valid);
    end
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 300; i++) begin
      fetch(8'h87);
      if (i == 99) begin
        checks++;
        if (hit_count !== 8'd101 || bus.mem_read_valid !== 1'b0) begin
          errors++;
          $display("FAIL hit_count_mid got h=%0d v=%b want 101 0", hit_count, bus.mem_read_valid);
        end
      end
      core_state = CoreDecode;
      step();
      core_state = CoreExec;
    end
    checks++;
    if (hit_count !== 8'hFF || instruction !== 16'h5555) begin
      errors++;
      $display("FAIL hit_count_saturate got h=%h i=%h want ff 5555", hit_count, instruction);
    end
  endtask

  task automatic test_reset_fetching();
    fetch(8'h09);
    checks++;
    if (fetcher_state !== 3'b001) begin
      errors++;
      $display("FAIL pre_reset_fetching got st=%b want 001", fetcher_state);
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (fetcher_state !== 3'b000 || bus.mem_read_valid !== 1'b0 ||
        bus.mem_read_address !== 8'h00 || instruction !== 16'h0000 || hit_count !== 8'h00) begin
      errors++;
      $display("FAIL async_reset got st=%b v=%b a=%h i=%h h=%h want all zero",
               fetcher_state, bus.mem_read_valid, bus.mem_read_address, instruction, hit_count);
    end
    step();
    bus.mem_read_ready = 1'b1;
    bus.mem_read_data  = 16'hABCD;
    step();
    reset = 1'b1;
    step();
    step();
    bus.mem_read_ready = 1'b0;
    checks++;
    if (fetcher_state !== 3'b000 || instruction !== 16'h0000) begin
      errors++;
      $display("FAIL late_ready_ignored got st=%b i=%h want 000 0000", fetcher_state, instruction);
    end
    // Buffer was cleared, so even PC 0 (matching the reset buf_pc) must miss.
    fetch(8'h00);
    checks++;
    if (bus.mem_read_valid !== 1'b1 || fetcher_state !== 3'b001 || hit_count !== 8'h00) begin
      errors++;
      $display("FAIL first_fetch_miss got v=%b st=%b h=%0d want 1 001 0",
               bus.mem_read_valid, fetcher_state, hit_count);
    end
    respond(16'h0F0F);
    checks++;
    if (instruction !== 16'h0F0F || fetcher_state !== 3'b000) begin
      errors++;
      $display("FAIL post_reset_deliver got i=%h st=%b want 0f0f 000", instruction, fetcher_state);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b0;
    core_state = CoreExec;
    current_pc = 8'h00;
    flush = 1'b0;
    bus.mem_read_ready = 1'b0;
    bus.mem_read_data  = 16'h0000;
    step();
    step();
    test_reset();
    reset = 1'b1;
    step();
    test_miss();
    test_hit();
    test_flush();
    test_flush_with_ready();
    test_flush_with_hit();
    test_full_width_compare();
    test_ready_ignored();
    test_saturate();
    test_reset_fetching();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fetcher.md
FETCHER -- requirements
Module: fetcher

Interface
REQ-001 Parameter PROGRAM_MEM_ADDR_BITS, default 8, program memory address width and PC width.
REQ-002 Parameter PROGRAM_MEM_DATA_BITS, default 16, instruction width.
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-004 clk  input  1  clock; all state changes on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 core_state  input  4  core phase; FETCH = 4'b0001, DECODE = 4'b0010.
REQ-007 current_pc  input  PROGRAM_MEM_ADDR_BITS  PC to fetch, driven by the PC unit.
REQ-008 flush  input  1  invalidates the reuse buffer (asserted by the core after a PC redirect or stack pop).
REQ-009 mem_read_valid  output  1  program memory read request.
REQ-010 mem_read_address  output  PROGRAM_MEM_ADDR_BITS  program memory read address.
REQ-011 mem_read_ready  input  1  memory response valid; data accompanies it.
REQ-012 mem_read_data  input  PROGRAM_MEM_DATA_BITS  instruction returned by memory.
REQ-013 fetcher_state  output  3  IDLE = 3'b000, FETCHING = 3'b001, FETCHED = 3'b010.
REQ-014 instruction  output  PROGRAM_MEM_DATA_BITS  fetched instruction, stable while FETCHED.
REQ-015 hit_count  output  8  saturating count of buffer hits since reset.

Function
REQ-016 The block SHALL hold a one-entry reuse buffer: buf_pc, buf_instr, buf_valid.
REQ-017 IDLE, core_state == FETCH, buf_valid and buf_pc == current_pc: next cycle instruction <= buf_instr, state FETCHED, no memory request, hit_count increments unless at 255.
REQ-018 IDLE, core_state == FETCH, miss: next cycle mem_read_valid <= 1, mem_read_address <= current_pc, state FETCHING.
REQ-019 IDLE with core_state != FETCH SHALL hold all outputs.
REQ-020 FETCHING: mem_read_valid and mem_read_address SHALL stay constant until mem_read_ready is sampled high.
REQ-021 FETCHING, mem_read_ready high: same edge instruction <= mem_read_data, mem_read_valid <= 0, state FETCHED, buf_pc <= mem_read_address, buf_instr <= mem_read_data, buf_valid <= 1.
REQ-022 Miss latency SHALL be 1 request cycle plus memory wait; hit latency SHALL be exactly 1 cycle from FETCH sampled.
REQ-023 FETCHED: stay until core_state == DECODE is sampled, then IDLE; instruction SHALL keep its value in IDLE.
REQ-024 FETCHED with core_state == FETCH still asserted SHALL NOT start a new fetch.
REQ-025 flush high in any state SHALL clear buf_valid at the next edge.
REQ-026 flush does not abort an outstanding request; the returning instruction is delivered.
REQ-027 flush and mem_read_ready on the same edge: instruction delivered, buf_valid ends 0 (flush wins).
REQ-028 flush and a hit on the same edge in IDLE: treat as miss (flush wins), issue memory request.
REQ-029 mem_read_ready outside FETCHING SHALL be ignored.
REQ-030 The PC comparison SHALL be full-width equality; no partial or wrap-around matching.
REQ-031 hit_count SHALL saturate at 8'hFF and never wrap.

Reset
REQ-032 reset low SHALL immediately force fetcher_state IDLE, mem_read_valid 0, mem_read_address 0, instruction 0, buf_valid 0, buf_pc 0, buf_instr 0, hit_count 0.
REQ-033 Reset during FETCHING SHALL drop the request without waiting for mem_read_ready; a later ready SHALL be ignored.
REQ-034 After reset release, the first fetch SHALL always be a miss.

Verification
REQ-035 Miss: pc=8'h05, FETCH, memory ready 3 cycles later with 16'hA1B2 -> valid high 1 cycle after FETCH, addr 8'h05 held, instruction 16'hA1B2, state 3'b010.
REQ-036 Hit: repeat pc=8'h05 after DECODE -> FETCHED 1 cycle after FETCH, mem_read_valid never high, instruction 16'hA1B2, hit_count 1.
REQ-037 Flush: fetch 8'h05, pulse flush, fetch 8'h05 again -> memory request issued, hit_count unchanged.
REQ-038 Same-edge flush and ready on fetch of 8'h07 -> instruction delivered, next fetch of 8'h07 misses.
REQ-039 Reset low mid-FETCHING -> outputs zero asynchronously; later mem_read_ready has no effect.
REQ-040 300 consecutive hits on one PC -> hit_count stops at 8'hFF.
